// File: rtl/dromajo_commit_queue.sv
// rtl/dromajo_commit_queue.sv - compacting in-order commit/trap queue feeding a single-lane co-sim port
//
// Takes up to COMMIT_WIDTH commit records per cycle (any lane pattern) plus an
// optional trap. It packs them into a circular FIFO and drains one record per cycle.
//
// Ports:
//   clock, reset_n             clock and synchronous active-low reset
//   in_valid/in_pc/in_inst     per-lane commit records (lane i at [i*W +: W])
//   in_wdata/in_mstatus/in_check
//   in_int_xcpt/in_cause       trap request, ordered after this cycle's commits
//   in_ready                   room for a full cycle's worth of records
//   out_valid/out_is_trap/...  head record (all fields zero while empty)
//   out_ready                  consumer takes the head record
//   count                      occupancy
//   overflow                   sticky: an input cycle was dropped for lack of space
module dromajo_commit_queue #(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = 64,
    parameter int DEPTH        = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [COMMIT_WIDTH-1:0]      in_valid,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
    input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
    input  logic [COMMIT_WIDTH-1:0]      in_check,
    input  logic                         in_int_xcpt,
    input  logic [XLEN-1:0]              in_cause,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic                         out_is_trap,
    output logic [XLEN-1:0]              out_pc,
    output logic [31:0]                  out_inst,
    output logic [XLEN-1:0]              out_wdata,
    output logic [XLEN-1:0]              out_mstatus,
    output logic                         out_check,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BURST_C = CW'(COMMIT_WIDTH + 1);

    typedef struct packed {
        logic            is_trap;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] mstatus;
        logic            check;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [CW-1:0] n_in;
    logic [CW-1:0] free_slots;
    logic [CW-1:0] slot;
    logic [PW-1:0] widx;
    logic          accept;
    logic          deq;
    rec_t          rec;
    rec_t          head_rec;

    always_comb begin
        n_in = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            n_in = n_in + CW'(in_valid[i]);
        end
        n_in = n_in + CW'(in_int_xcpt);

        free_slots = DEPTH_C - count_q;
        // All-or-nothing: a cycle that does not fit is dropped whole.
        accept = (n_in <= free_slots);
        deq    = (count_q != '0) && out_ready;

        mem_d = mem_q;
        slot  = '0;
        widx  = tail_q;
        rec   = '0;
        if (accept) begin
            // Compaction: the k-th valid lane lands at tail+k.
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (in_valid[i]) begin
                    rec.is_trap = 1'b0;
                    rec.pc      = in_pc[i*XLEN +: XLEN];
                    rec.inst    = in_inst[i*32 +: 32];
                    rec.wdata   = in_wdata[i*XLEN +: XLEN];
                    rec.mstatus = in_mstatus[i*XLEN +: XLEN];
                    rec.check   = in_check[i];
                    widx        = tail_q + slot[PW-1:0];
                    mem_d[widx] = rec;
                    slot        = slot + 1'b1;
                end
            end
            if (in_int_xcpt) begin
                rec         = '0;
                rec.is_trap = 1'b1;
                rec.pc      = in_cause;
                widx        = tail_q + slot[PW-1:0];
                mem_d[widx] = rec;
            end
        end

        tail_d     = accept ? tail_q + n_in[PW-1:0] : tail_q;
        head_d     = head_q + PW'(deq);
        count_d    = count_q + (accept ? n_in : '0) - CW'(deq);
        overflow_d = overflow_q | ~accept;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the queue is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head_rec    = out_valid ? mem_q[head_q] : '0;
        out_is_trap = head_rec.is_trap;
        out_pc      = head_rec.pc;
        out_inst    = head_rec.inst;
        out_wdata   = head_rec.wdata;
        out_mstatus = head_rec.mstatus;
        out_check   = head_rec.check;
    end

    assign out_valid = (count_q != '0);
    // Decided on the pre-dequeue count so a full burst always fits.
    assign in_ready  = (DEPTH_C - count_q) >= BURST_C;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dromajo_commit_queue.sv
// tb/tb_dromajo_commit_queue.sv - scoreboard bench for dromajo_commit_queue
module tb_dromajo_commit_queue;

    localparam int CWID = 2;
    localparam int XL   = 64;
    localparam int DEP  = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [CWID-1:0]   in_valid;
    logic [XL*CWID-1:0] in_pc;
    logic [32*CWID-1:0] in_inst;
    logic [XL*CWID-1:0] in_wdata;
    logic [XL*CWID-1:0] in_mstatus;
    logic [CWID-1:0]   in_check;
    logic              in_int_xcpt;
    logic [XL-1:0]     in_cause;
    logic              in_ready;
    logic              out_valid;
    logic              out_is_trap;
    logic [XL-1:0]     out_pc;
    logic [31:0]       out_inst;
    logic [XL-1:0]     out_wdata;
    logic [XL-1:0]     out_mstatus;
    logic              out_check;
    logic              out_ready;
    logic [4:0]        count;
    logic              overflow;

    dromajo_commit_queue #(.COMMIT_WIDTH(CWID), .XLEN(XL), .DEPTH(DEP)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_wdata(in_wdata), .in_mstatus(in_mstatus), .in_check(in_check),
        .in_int_xcpt(in_int_xcpt), .in_cause(in_cause), .in_ready(in_ready),
        .out_valid(out_valid), .out_is_trap(out_is_trap), .out_pc(out_pc),
        .out_inst(out_inst), .out_wdata(out_wdata), .out_mstatus(out_mstatus),
        .out_check(out_check), .out_ready(out_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          is_trap;
        logic [XL-1:0] pc;
        logic [31:0]   inst;
        logic [XL-1:0] wdata;
        logic [XL-1:0] mstatus;
        logic          check;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Head record is compared on the negedge before the edge that consumes it.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_out", 64'd1, 64'd0);
            end else begin
                rec_t e;
                e = sb.pop_front();
                check_eq("out_is_trap", 64'(out_is_trap), 64'(e.is_trap));
                check_eq("out_pc",      out_pc,           e.pc);
                check_eq("out_inst",    64'(out_inst),    64'(e.inst));
                check_eq("out_wdata",   out_wdata,        e.wdata);
                check_eq("out_mstatus", out_mstatus,      e.mstatus);
                check_eq("out_check",   64'(out_check),   64'(e.check));
            end
        end
    end

    // One input cycle; expected records are pushed unless the cycle is meant to be dropped.
    task automatic send(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                        input logic x, input logic [63:0] cause, input bit push);
        logic [63:0] pcs [2];
        rec_t r;
        pcs[0] = p0;
        pcs[1] = p1;
        in_valid    = v;
        in_pc       = {p1, p0};
        in_inst     = {$urandom, $urandom};
        in_wdata    = {$urandom, $urandom, $urandom, $urandom};
        in_mstatus  = {$urandom, $urandom, $urandom, $urandom};
        in_check    = 2'($urandom_range(0, 3));
        in_int_xcpt = x;
        in_cause    = cause;
        if (push) begin
            for (int i = 0; i < CWID; i++) begin
                if (v[i]) begin
                    r.is_trap = 1'b0;
                    r.pc      = pcs[i];
                    r.inst    = in_inst[i*32 +: 32];
                    r.wdata   = in_wdata[i*XL +: XL];
                    r.mstatus = in_mstatus[i*XL +: XL];
                    r.check   = in_check[i];
                    sb.push_back(r);
                end
            end
            if (x) begin
                r = '0;
                r.is_trap = 1'b1;
                r.pc      = cause;
                sb.push_back(r);
            end
        end
        @(posedge clock);
        #1;
        in_valid    = '0;
        in_int_xcpt = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        for (int k = 0; k < budget && count != 0; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    logic [63:0] pc_seq;

    initial begin
        reset_n = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_pc = '0; in_inst = '0; in_wdata = '0; in_mstatus = '0;
        in_check = '0; in_int_xcpt = 1'b0; in_cause = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_count",     64'(count),     64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_overflow",  64'(overflow),  64'd0);
        check_eq("rst_out_pc",    out_pc,         64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Two-lane commit drained in lane order.
        out_ready = 1'b1;
        send(2'b11, 64'h8000_0000, 64'h8000_0004, 1'b0, 64'd0, 1'b1);
        check_eq("t1_out_valid", 64'(out_valid), 64'd1);
        wait_empty(20);
        check_eq("t1_count", 64'(count), 64'd0);

        // Lane 0 invalid: lane 1 compacts into a single record.
        out_ready = 1'b0;
        send(2'b10, 64'hdead, 64'h1000, 1'b0, 64'd0, 1'b1);
        check_eq("t2_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        wait_empty(20);
        check_eq("t2_count_end", 64'(count), 64'd0);

        // Commit plus trap in one cycle.
        out_ready = 1'b0;
        send(2'b01, 64'h2000, 64'hbeef, 1'b1, 64'h8000_0000_0000_0007, 1'b1);
        check_eq("t3_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        wait_empty(20);
        check_eq("t3_count_end", 64'(count), 64'd0);

        // Trap alone.
        send(2'b00, 64'd0, 64'd0, 1'b1, 64'h3, 1'b1);
        wait_empty(20);
        check_eq("t3b_count_end", 64'(count), 64'd0);

        // Fill to the brim, then one dropped cycle.
        out_ready = 1'b0;
        pc_seq = 64'h4000;
        for (int c = 0; c < 7; c++) begin
            send(2'b11, pc_seq, pc_seq + 4, 1'b0, 64'd0, 1'b1);
            pc_seq += 8;
        end
        check_eq("t4_count14",  64'(count),    64'd14);
        check_eq("t4_in_ready", 64'(in_ready), 64'd0);
        send(2'b11, pc_seq, pc_seq + 4, 1'b0, 64'd0, 1'b1);
        pc_seq += 8;
        check_eq("t4_count16",   64'(count),    64'd16);
        check_eq("t4_no_ovf",    64'(overflow), 64'd0);
        send(2'b01, 64'h9999, 64'd0, 1'b0, 64'd0, 1'b0);
        check_eq("t4_ovf",       64'(overflow), 64'd1);
        check_eq("t4_count_ovf", 64'(count),    64'd16);

        // Drain to 5 then reset mid-operation.
        out_ready = 1'b1;
        repeat (11) begin
            @(posedge clock);
            #1;
        end
        check_eq("t5_count5", 64'(count), 64'd5);
        out_ready = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        sb.delete();
        reset_n = 1'b1;
        check_eq("t5_count",     64'(count),     64'd0);
        check_eq("t5_out_valid", 64'(out_valid), 64'd0);
        check_eq("t5_overflow",  64'(overflow),  64'd0);
        check_eq("t5_in_ready",  64'(in_ready),  64'd1);

        // Fill to 10, then stream with wrap-around, respecting in_ready.
        pc_seq = 64'h10_0000;
        for (int c = 0; c < 5; c++) begin
            send(2'b11, pc_seq, pc_seq + 4, 1'b0, 64'd0, 1'b1);
            pc_seq += 8;
        end
        check_eq("t6_count10", 64'(count), 64'd10);
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_ready) begin
                send(2'b11, pc_seq, pc_seq + 4, 1'b0, 64'd0, 1'b1);
                pc_seq += 8;
            end else begin
                @(posedge clock);
                #1;
            end
            check_eq("t6_count_le16", 64'(count <= 5'd16), 64'd1);
        end
        wait_empty(100);
        check_eq("t6_count_end", 64'(count),    64'd0);
        check_eq("t6_overflow",  64'(overflow), 64'd0);
        check_eq("t6_sb_empty",  64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
